collide_scheduler: RTL and testbench
====================================

Name: collide_scheduler

Overview:
- Sequential, resource-shared replacement for the all-parallel collision check.
- On a frame `start` pulse, snapshots the packed object list and finds the player by iterating over slots. It then scans enemies one slot per cycle through a single overlap comparator.
- Reports `collide` and `hit_index` with a one-cycle `done` pulse.
- Sits between the frame/game-state sequencer (which issues `start` once per frame) and the game-over logic.

Parameters:
- DATACOUNT, 8, number of object slots in gamedata.
- DATALEN, 44, bits per object slot; the field layout comes from the shared package.
- IDXW, 3, width of slot index; equals clog2(DATACOUNT).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to evaluate gamedata; sampled only in IDLE.
- gamedata  input  DATALEN*DATACOUNT  packed object slots; slot i = bits [i*DATALEN +: DATALEN].
- busy  output  1  high in FIND and SCAN.
- done  output  1  one-cycle pulse when the result is valid.
- collide  output  1  result of the last evaluation; held until the next `done`.
- hit_index  output  IDXW  slot of the first overlapping enemy; 0 when collide=0.
- player_found  output  1  a player slot existed in the last snapshot; held like collide.

Behaviour:
- Reset (synchronous, active-high, any state, including mid-scan):
  - state=IDLE.
  - busy=0, done=0, collide=0, hit_index=0, player_found=0.
  - Snapshot and index counters cleared.
- States: IDLE, FIND, SCAN, DONE.
- IDLE:
  - start=1 at cycle t captures gamedata into the snapshot register, clears idx and player_valid, and goes to FIND.
  - start is ignored in all other states, with no queuing.
- FIND (cycles t+1 .. t+N, N=DATACOUNT):
  - Examines snapshot slot idx.
  - If type is in [PLAYER_START, PLAYER_END], latch player_idx=idx and set player_valid. The last matching slot wins.
  - After idx=N-1: if player_valid, go to SCAN with idx=0; otherwise go to DONE.
- SCAN (slot j examined at cycle t+N+1+j):
  - If slot j type == ENEMY_TYPE and the pair overlaps, record hit and go to DONE.
  - Otherwise, if j=N-1, go to DONE (no hit); else advance idx.
  - Slots whose type is not ENEMY_TYPE never hit, including the player slot itself.
- DONE: lasts one cycle.
  - done=1.
  - collide, hit_index and player_found are registered at entry, so they are valid in the same cycle as done.
  - Next state is IDLE. The earliest next start is accepted the cycle after DONE.
- Latency from the start cycle t:
  - No player: done at t+N+1.
  - Hit at slot j: done at t+N+2+j.
  - Player but no hit: done at t+2N+1.
- Overlap rule (per axis):
  - X overlaps iff NOT(p.x+p.w < e.x OR e.x+e.w < p.x).
  - Y uses the same rule with y and h.
  - Sums are computed at field width+1 (no wrap-around). Compares are unsigned.
  - Edge touching (p.x+p.w == e.x) counts as a collision.
- The snapshot isolates the scan from gamedata changes during busy.
- Multiple enemies overlapping: the lowest slot index is reported.

Decomposition:
- Shared package `game_pkg` holds:
  - Field offsets and lengths: TYPE, X, Y, WIDTH, HEIGHT start/len.
  - DATALEN and DATACOUNT defaults.
  - Type codes PLAYER_START, PLAYER_END, ENEMY_TYPE.
  - State enum for collide_scheduler.
- One sub-module, `collide_pair`: purely combinational overlap check of two object slots, output `overlap`. It is instantiated once.

Test Plan:
- No player: reset, then start with all slots ENEMY_TYPE -> done at t+9, collide=0, player_found=0, hit_index=0.
- Hit at slot 5: player in slot 2 at (x=10,y=20,w=8,h=8); enemy in slot 5 at (x=15,y=22,w=4,h=4); all other slots empty type -> done at t+15, collide=1, hit_index=5, player_found=1.
- Edge touch and gap, with the same player at x=10, w=8:
  - Enemy at x=18 -> collide=1.
  - Enemy at x=19 -> collide=0, done at t+17.
- Overflow and first-hit selection:
  - Player x=1020, w=8 with 10-bit X (sum 1028, no wrap) against enemy at x=2 -> collide=0.
  - Two overlapping enemies in slots 3 and 6 -> hit_index=3.
- Robustness:
  - Start pulsed again while busy -> ignored, with a single done.
  - gamedata changed mid-scan -> result follows the snapshot.
  - reset asserted at t+10 -> the next cycle shows IDLE with all outputs 0, and no done follows.

Source files
------------

// File: rtl/game_pkg.sv
// Shared object-slot layout, type codes and scheduler state encoding.
// Every module that decodes gamedata slots imports this package.
package game_pkg;

    // Default slot geometry
    localparam int DATACOUNT = 8;
    localparam int DATALEN   = 44;
    localparam int IDXW      = 3;

    // Field layout inside one slot (LSB first)
    localparam int TYPE_START   = 0;
    localparam int TYPE_LEN     = 4;
    localparam int X_START      = 4;
    localparam int X_LEN        = 10;
    localparam int Y_START      = 14;
    localparam int Y_LEN        = 10;
    localparam int WIDTH_START  = 24;
    localparam int WIDTH_LEN    = 10;
    localparam int HEIGHT_START = 34;
    localparam int HEIGHT_LEN   = 10;

    // Object type codes
    localparam logic [TYPE_LEN-1:0] TYPE_EMPTY   = 4'd0;
    localparam logic [TYPE_LEN-1:0] PLAYER_START = 4'd1;
    localparam logic [TYPE_LEN-1:0] PLAYER_END   = 4'd3;
    localparam logic [TYPE_LEN-1:0] ENEMY_TYPE   = 4'd4;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIND = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } sched_state_e;

    // Extract the type field of one slot
    function automatic logic [TYPE_LEN-1:0] obj_type(input logic [DATALEN-1:0] slot);
        return slot[TYPE_START +: TYPE_LEN];
    endfunction

    // True when a type code lies in the player range
    function automatic logic is_player(input logic [TYPE_LEN-1:0] t);
        return (t >= PLAYER_START) && (t <= PLAYER_END);
    endfunction

endpackage

// File: rtl/collide_pair.sv
// Combinational axis-aligned overlap test between two object slots.
// Right/bottom edges are formed one bit wider than the field so a box
// near the top of the coordinate range never wraps back to a small value.
// Touching edges count as overlap.
module collide_pair
    import game_pkg::*;
(
    input  logic [DATALEN-1:0] obj_a,
    input  logic [DATALEN-1:0] obj_b,
    output logic               overlap
);

    logic [X_LEN-1:0]      a_x, b_x;
    logic [WIDTH_LEN-1:0]  a_w, b_w;
    logic [Y_LEN-1:0]      a_y, b_y;
    logic [HEIGHT_LEN-1:0] a_h, b_h;

    logic [X_LEN:0] a_x_end, b_x_end;
    logic [Y_LEN:0] a_y_end, b_y_end;
    logic           x_overlap, y_overlap;

    assign a_x = obj_a[X_START      +: X_LEN];
    assign b_x = obj_b[X_START      +: X_LEN];
    assign a_w = obj_a[WIDTH_START  +: WIDTH_LEN];
    assign b_w = obj_b[WIDTH_START  +: WIDTH_LEN];
    assign a_y = obj_a[Y_START      +: Y_LEN];
    assign b_y = obj_b[Y_START      +: Y_LEN];
    assign a_h = obj_a[HEIGHT_START +: HEIGHT_LEN];
    assign b_h = obj_b[HEIGHT_START +: HEIGHT_LEN];

    // Widened edge sums and the per-axis separation test
    always_comb begin
        a_x_end   = {1'b0, a_x} + {1'b0, a_w};
        b_x_end   = {1'b0, b_x} + {1'b0, b_w};
        a_y_end   = {1'b0, a_y} + {1'b0, a_h};
        b_y_end   = {1'b0, b_y} + {1'b0, b_h};
        x_overlap = !((a_x_end < {1'b0, b_x}) || (b_x_end < {1'b0, a_x}));
        y_overlap = !((a_y_end < {1'b0, b_y}) || (b_y_end < {1'b0, a_y}));
        overlap   = x_overlap && y_overlap;
    end

endmodule

// File: rtl/collide_scheduler.sv
// Sequential collision checker: snapshots the object list on start,
// locates the player (last matching slot wins), then walks the enemy
// slots one per cycle through a single shared overlap comparator and
// reports the lowest overlapping enemy with a one-cycle done pulse.
module collide_scheduler
    import game_pkg::*;
#(
    parameter int DATACOUNT = game_pkg::DATACOUNT,
    parameter int DATALEN   = game_pkg::DATALEN,
    parameter int IDXW      = game_pkg::IDXW
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [DATALEN*DATACOUNT-1:0]  gamedata,
    output logic                          busy,
    output logic                          done,
    output logic                          collide,
    output logic [IDXW-1:0]               hit_index,
    output logic                          player_found
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DATACOUNT - 1);

    sched_state_e                  state_q, state_d;
    logic [DATALEN*DATACOUNT-1:0]  snap_q, snap_d;
    logic [IDXW-1:0]               idx_q, idx_d;
    logic [IDXW-1:0]               player_idx_q, player_idx_d;
    logic                          player_valid_q, player_valid_d;
    logic                          collide_q, collide_d;
    logic [IDXW-1:0]               hit_index_q, hit_index_d;
    logic                          player_found_q, player_found_d;

    logic [DATALEN-1:0] slots [DATACOUNT];
    logic [DATALEN-1:0] cur_slot;
    logic [DATALEN-1:0] player_slot;
    logic               pair_overlap;

    // Unpack the snapshot into addressable slots
    always_comb begin
        for (int i = 0; i < DATACOUNT; i++) begin
            slots[i] = snap_q[i*DATALEN +: DATALEN];
        end
    end

    assign cur_slot    = slots[idx_q];
    assign player_slot = slots[player_idx_q];

    collide_pair u_pair (
        .obj_a   (player_slot),
        .obj_b   (cur_slot),
        .overlap (pair_overlap)
    );

    // Next-state, counter and result logic
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a value
        // unassigned (which would infer a latch); blocking '=' is correct
        // here because this block describes combinational logic.
        state_d        = state_q;
        snap_d         = snap_q;
        idx_d          = idx_q;
        player_idx_d   = player_idx_q;
        player_valid_d = player_valid_q;
        collide_d      = collide_q;
        hit_index_d    = hit_index_q;
        player_found_d = player_found_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d         = gamedata;
                    idx_d          = '0;
                    player_valid_d = 1'b0;
                    state_d        = FIND;
                end
            end

            FIND: begin
                if (is_player(obj_type(cur_slot))) begin
                    player_idx_d   = idx_q;
                    player_valid_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    // player_valid_d already includes a match on this last slot
                    if (player_valid_d) begin
                        state_d = SCAN;
                    end else begin
                        state_d        = DONE;
                        collide_d      = 1'b0;
                        hit_index_d    = '0;
                        player_found_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            SCAN: begin
                if ((obj_type(cur_slot) == ENEMY_TYPE) && pair_overlap) begin
                    state_d        = DONE;
                    collide_d      = 1'b1;
                    hit_index_d    = idx_q;
                    player_found_d = 1'b1;
                end else if (idx_q == LAST_IDX) begin
                    state_d        = DONE;
                    collide_d      = 1'b0;
                    hit_index_d    = '0;
                    player_found_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so all flops update
        // together from values sampled at the same edge.
        if (reset) begin
            state_q        <= IDLE;
            // NOTE: the snapshot is wide but still cleared on reset so a
            // post-reset frame never sees stale objects from before reset.
            snap_q         <= '0;
            idx_q          <= '0;
            player_idx_q   <= '0;
            player_valid_q <= 1'b0;
            collide_q      <= 1'b0;
            hit_index_q    <= '0;
            player_found_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            snap_q         <= snap_d;
            idx_q          <= idx_d;
            player_idx_q   <= player_idx_d;
            player_valid_q <= player_valid_d;
            collide_q      <= collide_d;
            hit_index_q    <= hit_index_d;
            player_found_q <= player_found_d;
        end
    end

    assign busy         = (state_q == FIND) || (state_q == SCAN);
    assign done         = (state_q == DONE);
    assign collide      = collide_q;
    assign hit_index    = hit_index_q;
    assign player_found = player_found_q;

endmodule

// File: tb/tb_collide_scheduler.sv
// Directed bench for collide_scheduler: hand-built object lists with
// hand-computed latency and result for each frame.
module tb_collide_scheduler;
    import game_pkg::*;

    localparam int N       = 8;
    localparam int MAX_LAT = 40;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic [DATALEN*N-1:0]     gamedata;
    logic                     busy, done, collide, player_found;
    logic [IDXW-1:0]          hit_index;

    logic [DATALEN-1:0]       slot_v [N];
    logic [DATALEN*N-1:0]     alt_gamedata;

    int checks = 0;
    int errors = 0;

    int r_lat, r_collide, r_hit, r_pf, r_done_next;

    always #5 clk = ~clk;

    collide_scheduler #(
        .DATACOUNT (N),
        .DATALEN   (DATALEN),
        .IDXW      (IDXW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .gamedata     (gamedata),
        .busy         (busy),
        .done         (done),
        .collide      (collide),
        .hit_index    (hit_index),
        .player_found (player_found)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DATALEN-1:0] mk(input logic [3:0] t, input int x, input int y,
                                             input int w, input int h);
        logic [DATALEN-1:0] s;
        s = '0;
        s[TYPE_START   +: TYPE_LEN]   = t;
        s[X_START      +: X_LEN]      = X_LEN'(x);
        s[Y_START      +: Y_LEN]      = Y_LEN'(y);
        s[WIDTH_START  +: WIDTH_LEN]  = WIDTH_LEN'(w);
        s[HEIGHT_START +: HEIGHT_LEN] = HEIGHT_LEN'(h);
        return s;
    endfunction

    task automatic clear_slots();
        for (int i = 0; i < N; i++) slot_v[i] = mk(TYPE_EMPTY, 0, 0, 0, 0);
    endtask

    task automatic load();
        for (int i = 0; i < N; i++) gamedata[i*DATALEN +: DATALEN] = slot_v[i];
    endtask

    // Pulse start, optionally re-pulse start or swap gamedata while busy,
    // wait (bounded) for done, capture results and the following cycle's done.
    task automatic run(input int restart_at, input int mutate_at);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        r_lat = 1;
        while (done !== 1'b1 && r_lat < MAX_LAT) begin
            start = (r_lat == restart_at);
            if (r_lat == mutate_at) gamedata = alt_gamedata;
            @(negedge clk);
            r_lat++;
        end
        start = 1'b0;
        if (done !== 1'b1) check("done_timeout", 32'(done), 1);
        r_collide = int'(collide);
        r_hit     = int'(hit_index);
        r_pf      = int'(player_found);
        @(negedge clk);
        r_done_next = int'(done);
    endtask

    initial begin
        int dones;

        reset    = 1'b1;
        start    = 1'b0;
        gamedata = '0;
        alt_gamedata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_collide", 32'(collide), 0);
        check("rst_hit", 32'(hit_index), 0);
        check("rst_pf", 32'(player_found), 0);
        reset = 1'b0;
        @(negedge clk);

        // No player: every slot is an enemy
        for (int i = 0; i < N; i++) slot_v[i] = mk(ENEMY_TYPE, 10, 20, 8, 8);
        load();
        run(-1, -1);
        check("nop_lat", 32'(r_lat), 9);
        check("nop_collide", 32'(r_collide), 0);
        check("nop_pf", 32'(r_pf), 0);
        check("nop_hit", 32'(r_hit), 0);
        check("nop_done_pulse", 32'(r_done_next), 0);

        // Hit at slot 5; a non-enemy overlapping object in slot 0 never hits
        clear_slots();
        slot_v[2] = mk(PLAYER_START, 10, 20, 8, 8);
        slot_v[5] = mk(ENEMY_TYPE, 15, 22, 4, 4);
        load();
        run(-1, -1);
        check("hit5_lat", 32'(r_lat), 15);
        check("hit5_collide", 32'(r_collide), 1);
        check("hit5_hit", 32'(r_hit), 5);
        check("hit5_pf", 32'(r_pf), 1);
        check("hit5_done_pulse", 32'(r_done_next), 0);
        check("hit5_held", 32'(collide), 1);

        slot_v[0] = mk(4'd5, 10, 20, 8, 8);
        load();
        run(-1, -1);
        check("nonenemy_hit", 32'(r_hit), 5);
        check("nonenemy_lat", 32'(r_lat), 15);

        // No player after a hit: results are overwritten
        for (int i = 0; i < N; i++) slot_v[i] = mk(ENEMY_TYPE, 10, 20, 8, 8);
        load();
        run(-1, -1);
        check("nop2_collide", 32'(r_collide), 0);
        check("nop2_hit", 32'(r_hit), 0);
        check("nop2_pf", 32'(r_pf), 0);

        // Edge touch: 10+8 == 18
        clear_slots();
        slot_v[2] = mk(PLAYER_START, 10, 20, 8, 8);
        slot_v[5] = mk(ENEMY_TYPE, 18, 22, 4, 4);
        load();
        run(-1, -1);
        check("touch_collide", 32'(r_collide), 1);
        check("touch_hit", 32'(r_hit), 5);

        // One-pixel gap: no hit, full scan
        slot_v[5] = mk(ENEMY_TYPE, 19, 22, 4, 4);
        load();
        run(-1, -1);
        check("gap_collide", 32'(r_collide), 0);
        check("gap_lat", 32'(r_lat), 17);
        check("gap_pf", 32'(r_pf), 1);
        check("gap_hit", 32'(r_hit), 0);

        // Overflow: player right edge 1028 must not wrap to 4
        clear_slots();
        slot_v[1] = mk(PLAYER_END, 1020, 20, 8, 8);
        slot_v[4] = mk(ENEMY_TYPE, 2, 22, 4, 4);
        load();
        run(-1, -1);
        check("ovf_far_collide", 32'(r_collide), 0);

        // Both near the top: player 1020..1028, enemy 1022..1026 overlap
        slot_v[4] = mk(ENEMY_TYPE, 1022, 22, 4, 4);
        load();
        run(-1, -1);
        check("ovf_near_collide", 32'(r_collide), 1);
        check("ovf_near_hit", 32'(r_hit), 4);

        // Two overlapping enemies: lowest index wins
        clear_slots();
        slot_v[0] = mk(PLAYER_START, 10, 20, 8, 8);
        slot_v[3] = mk(ENEMY_TYPE, 12, 21, 2, 2);
        slot_v[6] = mk(ENEMY_TYPE, 14, 24, 3, 3);
        load();
        run(-1, -1);
        check("first_hit", 32'(r_hit), 3);
        check("first_lat", 32'(r_lat), 13);

        // Two players: the last one (slot 4) is used
        clear_slots();
        slot_v[1] = mk(PLAYER_START, 500, 500, 8, 8);
        slot_v[4] = mk(4'd2, 10, 20, 8, 8);
        slot_v[6] = mk(ENEMY_TYPE, 15, 22, 4, 4);
        load();
        run(-1, -1);
        check("lastplayer_collide", 32'(r_collide), 1);
        check("lastplayer_hit", 32'(r_hit), 6);

        // Start re-pulsed while busy: ignored, single done
        clear_slots();
        slot_v[2] = mk(PLAYER_START, 10, 20, 8, 8);
        slot_v[5] = mk(ENEMY_TYPE, 15, 22, 4, 4);
        load();
        run(3, -1);
        check("restart_lat", 32'(r_lat), 15);
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("restart_extra_done", 32'(dones), 0);
        check("restart_busy", 32'(busy), 0);

        // gamedata cleared during SCAN: result follows the snapshot
        alt_gamedata = '0;
        run(-1, 10);
        check("snap_collide", 32'(r_collide), 1);
        check("snap_hit", 32'(r_hit), 5);
        check("snap_lat", 32'(r_lat), 15);

        // Reset at t+10 mid-scan: IDLE next cycle, outputs cleared, no done
        load();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_collide", 32'(collide), 0);
        check("midrst_hit", 32'(hit_index), 0);
        check("midrst_pf", 32'(player_found), 0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("midrst_no_done", 32'(dones), 0);

        // Frame after reset still works
        run(-1, -1);
        check("post_rst_hit", 32'(r_hit), 5);
        check("post_rst_collide", 32'(r_collide), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
